wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port among three requesters:
  - debug write port (dbg), fixed highest priority;
  - ALU writeback (alu);
  - load/store unit writeback (lsu), round-robin with alu.
- Sits between the execute/memory stages and the register file. Its write outputs are registered through a load-enabled, async-reset flop stage.
- Carries a one-bit round-robin priority state. Supports a global hold that freezes all grants.

Parameters:
- DW, 32, write data width.
- AW, 5, register address width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- wb_hold  input  1  blocks all grants while high.
- dbg_valid  input  1  debug write request.
- dbg_ready  output  1  debug request accepted this cycle.
- dbg_rd  input  AW  debug destination register.
- dbg_data  input  DW  debug write data.
- alu_valid  input  1  ALU write request.
- alu_ready  output  1  ALU request accepted this cycle.
- alu_rd  input  AW  ALU destination register.
- alu_data  input  DW  ALU result.
- lsu_valid  input  1  LSU write request.
- lsu_ready  output  1  LSU request accepted this cycle.
- lsu_rd  input  AW  LSU destination register.
- lsu_data  input  DW  load data.
- rf_wen  output  1  register-file write enable (registered).
- rf_waddr  output  AW  register-file write address (registered).
- rf_wdata  output  DW  register-file write data (registered).
- rr_prio_lsu  output  1  current round-robin pointer (1 = lsu preferred).

Behaviour:
- Reset and clock:
  - rst is asynchronous and active-high; clk is the clock. All state is updated on the rising edge of clk.
  - Reset values: rf_wen=0, rf_waddr=0, rf_wdata=0, rr_prio_lsu=0 (alu preferred).
  - The ready outputs are combinational. They are 0 whenever rst is high.
- Handshake:
  - A transfer occurs when valid and ready are both high at a rising edge.
  - After asserting valid, a requester holds valid, rd and data stable until the transfer.
  - ready may depend on valid, but requesters must not wait for ready before asserting valid.
- Grant (combinational, one grant per cycle at most):
  - If wb_hold is high, all ready outputs are 0.
  - Otherwise, if dbg_valid is high, dbg_ready=1.
  - Otherwise, if exactly one of alu_valid/lsu_valid is high, that requester is granted.
  - Otherwise, if both are high, the requester selected by rr_prio_lsu is granted.
- Round-robin pointer:
  - On an alu transfer, rr_prio_lsu becomes 1. On an lsu transfer, it becomes 0.
  - dbg transfers and idle cycles leave it unchanged.
  - Two continuously valid requesters therefore alternate grants every cycle.
  - dbg can starve alu/lsu indefinitely; that is by design.
- Output stage:
  - On a transfer at edge N, rf_wen, rf_waddr and rf_wdata reflect the granted request for exactly the cycle after edge N. This is one-cycle latency.
  - rf_waddr and rf_wdata load only on a transfer; otherwise they hold their previous values.
  - rf_wen is 0 in any cycle not following a transfer.
  - If the granted rd is 0, the transfer still completes (ready high), but rf_wen stays 0. rf_waddr/rf_wdata may still load.
- Back-to-back: a new transfer may occur every cycle. rf_wen stays high continuously across consecutive nonzero-rd transfers.
- wb_hold rising:
  - Any transfer completed on the prior edge still produces its rf_wen pulse.
  - No new transfer occurs while wb_hold is high; the round-robin pointer is frozen.
- Reset mid-operation: a transfer accepted on the last edge before rst asserts is lost (rf_wen forced to 0 immediately). Requesters must re-present requests after reset.
- No register-file backpressure exists. Every transfer is guaranteed a write slot.

Test Plan:
- Reset check: assert rst mid-cycle with rf_wen=1 -> rf_wen, rf_waddr, rf_wdata and rr_prio_lsu go to 0 immediately, without waiting for a clock edge.
- Single alu write: alu_valid=1, rd=3, data=0x12345678 -> alu_ready=1 that cycle. Next cycle rf_wen=1, rf_waddr=3, rf_wdata=0x12345678, rr_prio_lsu=1.
- Contention: alu and lsu valid for 4 cycles from reset (rd=1 and rd=2) -> grants alu, lsu, alu, lsu. rf_waddr sequence 1,2,1,2 with rf_wen high 4 consecutive cycles.
- Debug priority: dbg, alu and lsu all valid with rr_prio_lsu=1 -> dbg granted; rr_prio_lsu stays 1. The next cycle without dbg_valid grants lsu.
- x0 and hold: alu rd=0 -> alu_ready=1, rf_wen stays 0. Then wb_hold=1 for 3 cycles with lsu valid -> lsu_ready=0 throughout. lsu is granted in the first cycle after hold drops.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: debug wins outright, ALU and LSU share the port round-robin.
// The winning request is registered one cycle before it reaches the register file.
module wb_port_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_hold,
  input  logic          dbg_valid,
  output logic          dbg_ready,
  input  logic [AW-1:0] dbg_rd,
  input  logic [DW-1:0] dbg_data,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  input  logic          lsu_valid,
  output logic          lsu_ready,
  input  logic [AW-1:0] lsu_rd,
  input  logic [DW-1:0] lsu_data,
  output logic          rf_wen,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          rr_prio_lsu
);

  logic          any_xfer;
  logic [AW-1:0] sel_rd;
  logic [DW-1:0] sel_data;

  // Each ready already implies its valid, so a ready is a transfer at the next edge.
  always_comb begin
    dbg_ready = 1'b0;
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (!rst && !wb_hold) begin
      if (dbg_valid) begin
        dbg_ready = 1'b1;
      end else if (alu_valid && lsu_valid) begin
        lsu_ready = rr_prio_lsu;
        alu_ready = !rr_prio_lsu;
      end else if (alu_valid) begin
        alu_ready = 1'b1;
      end else if (lsu_valid) begin
        lsu_ready = 1'b1;
      end
    end
  end

  assign any_xfer = dbg_ready | alu_ready | lsu_ready;

  always_comb begin
    sel_rd   = lsu_rd;
    sel_data = lsu_data;
    if (dbg_ready) begin
      sel_rd   = dbg_rd;
      sel_data = dbg_data;
    end else if (alu_ready) begin
      sel_rd   = alu_rd;
      sel_data = alu_data;
    end
  end

  // Writes to x0 still complete the handshake but never raise the write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wen      <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      rr_prio_lsu <= 1'b0;
    end else begin
      rf_wen <= any_xfer && (sel_rd != '0);
      if (any_xfer) begin
        rf_waddr <= sel_rd;
        rf_wdata <= sel_data;
      end
      if (alu_ready) begin
        rr_prio_lsu <= 1'b1;
      end else if (lsu_ready) begin
        rr_prio_lsu <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a reference model predicts each cycle's grant and
// the registered write that must appear one cycle later.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_hold = 1'b0;
  logic        dbg_valid = 1'b0, alu_valid = 1'b0, lsu_valid = 1'b0;
  logic        dbg_ready, alu_ready, lsu_ready;
  logic [4:0]  dbg_rd = '0, alu_rd = '0, lsu_rd = '0;
  logic [31:0] dbg_data = '0, alu_data = '0, lsu_data = '0;
  logic        rf_wen, rr_prio_lsu;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_exp_t;

  wb_exp_t    exp_q[$];
  wb_exp_t    e;
  logic       m_rr;
  logic [4:0] m_addr;
  logic [31:0] m_data;
  logic [2:0] exp_rdy;

  wb_port_arbiter #(.DW(32), .AW(5)) dut (
    .clk(clk), .rst(rst), .wb_hold(wb_hold),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_rd(dbg_rd), .dbg_data(dbg_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rr_prio_lsu(rr_prio_lsu)
  );

  always #5 clk = ~clk;

  // Predicts this cycle's grant as {dbg,alu,lsu}, queues the write it causes, advances the model.
  task automatic model_push(output logic [2:0] rdy);
    wb_exp_t ent;
    logic [4:0]  rd;
    logic [31:0] dat;
    rdy = 3'b000;
    if (!wb_hold) begin
      if (dbg_valid) rdy = 3'b100;
      else if (alu_valid && lsu_valid) rdy = m_rr ? 3'b001 : 3'b010;
      else if (alu_valid) rdy = 3'b010;
      else if (lsu_valid) rdy = 3'b001;
    end
    rd  = rdy[2] ? dbg_rd : (rdy[1] ? alu_rd : lsu_rd);
    dat = rdy[2] ? dbg_data : (rdy[1] ? alu_data : lsu_data);
    if (rdy != 3'b000) begin
      m_addr = rd;
      m_data = dat;
    end
    if (rdy[1]) m_rr = 1'b1;
    else if (rdy[0]) m_rr = 1'b0;
    ent.wen  = (rdy != 3'b000) && (rd != 5'd0);
    ent.addr = m_addr;
    ent.data = m_data;
    exp_q.push_back(ent);
  endtask

  task automatic drive(input logic hold, input logic dv, input logic [4:0] drd, input logic [31:0] dd,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    wb_hold = hold;
    dbg_valid = dv; dbg_rd = drd; dbg_data = dd;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
  endtask

  task automatic model_reset();
    m_rr = 1'b0;
    m_addr = '0;
    m_data = '0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    drive(0, 1, 5'd9, 32'hAAAA, 1, 5'd3, 32'h1, 1, 5'd4, 32'h2);
    #2;
    checks++;
    if ({dbg_ready, alu_ready, lsu_ready} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b want 000", {dbg_ready, alu_ready, lsu_ready});
    end
    checks++;
    if ({rf_wen, rf_waddr, rf_wdata, rr_prio_lsu} !== 39'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: wen=%b addr=%0d data=%h rr=%b want all 0",
               rf_wen, rf_waddr, rf_wdata, rr_prio_lsu);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_alu();
    for (int c = 0; c < 2; c++) begin
      if (c == 0) drive(0, 0, 0, 0, 1, 5'd3, 32'h12345678, 0, 0, 0);
      else        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_push(exp_rdy);
      #3;
      checks++;
      if ({dbg_ready, alu_ready, lsu_ready} !== exp_rdy) begin
        errors++;
        $display("[TB] FAIL single_ready c%0d: got %b want %b", c, {dbg_ready, alu_ready, lsu_ready}, exp_rdy);
      end
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({rf_wen, rf_waddr, rf_wdata, rr_prio_lsu} !== {e.wen, e.addr, e.data, m_rr}) begin
        errors++;
        $display("[TB] FAIL single_wb c%0d: got wen=%b addr=%0d data=%h rr=%b want wen=%b addr=%0d data=%h rr=%b",
                 c, rf_wen, rf_waddr, rf_wdata, rr_prio_lsu, e.wen, e.addr, e.data, m_rr);
      end
    end
  endtask

  task automatic test_contention();
    logic [4:0] want_addr[4] = '{5'd1, 5'd2, 5'd1, 5'd2};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 0, 0, 1, 5'd1, 32'hA0 + c, 1, 5'd2, 32'hB0 + c);
      model_push(exp_rdy);
      #3;
      checks++;
      if ({dbg_ready, alu_ready, lsu_ready} !== exp_rdy) begin
        errors++;
        $display("[TB] FAIL contention_ready c%0d: got %b want %b", c, {dbg_ready, alu_ready, lsu_ready}, exp_rdy);
      end
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({rf_wen, rf_waddr, rf_wdata} !== {e.wen, e.addr, e.data} || rf_waddr !== want_addr[c]) begin
        errors++;
        $display("[TB] FAIL contention_wb c%0d: got wen=%b addr=%0d data=%h want wen=%b addr=%0d data=%h",
                 c, rf_wen, rf_waddr, rf_wdata, e.wen, want_addr[c], e.data);
      end
    end
  endtask

  task automatic test_dbg_priority();
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: drive(0, 0, 0, 0, 1, 5'd4, 32'hC4, 0, 0, 0);
        1: drive(0, 1, 5'd31, 32'hDEADBEEF, 1, 5'd5, 32'hC5, 1, 5'd6, 32'hD6);
        default: drive(0, 0, 0, 0, 1, 5'd5, 32'hC5, 1, 5'd6, 32'hD6);
      endcase
      model_push(exp_rdy);
      #3;
      checks++;
      if ({dbg_ready, alu_ready, lsu_ready} !== exp_rdy) begin
        errors++;
        $display("[TB] FAIL dbg_ready c%0d: got %b want %b", c, {dbg_ready, alu_ready, lsu_ready}, exp_rdy);
      end
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({rf_wen, rf_waddr, rf_wdata, rr_prio_lsu} !== {e.wen, e.addr, e.data, m_rr}) begin
        errors++;
        $display("[TB] FAIL dbg_wb c%0d: got wen=%b addr=%0d data=%h rr=%b want wen=%b addr=%0d data=%h rr=%b",
                 c, rf_wen, rf_waddr, rf_wdata, rr_prio_lsu, e.wen, e.addr, e.data, m_rr);
      end
    end
  endtask

  task automatic test_x0_hold();
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: drive(0, 0, 0, 0, 1, 5'd0, 32'hFACE, 0, 0, 0);
        1: drive(0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 32'h99);
        2, 3, 4: drive(1, 0, 0, 0, 0, 0, 0, 1, 5'd10, 32'hA10);
        default: drive(0, 0, 0, 0, 0, 0, 0, 1, 5'd10, 32'hA10);
      endcase
      model_push(exp_rdy);
      #3;
      checks++;
      if ({dbg_ready, alu_ready, lsu_ready} !== exp_rdy) begin
        errors++;
        $display("[TB] FAIL x0_hold_ready c%0d: got %b want %b", c, {dbg_ready, alu_ready, lsu_ready}, exp_rdy);
      end
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({rf_wen, rf_waddr, rf_wdata, rr_prio_lsu} !== {e.wen, e.addr, e.data, m_rr}) begin
        errors++;
        $display("[TB] FAIL x0_hold_wb c%0d: got wen=%b addr=%0d data=%h rr=%b want wen=%b addr=%0d data=%h rr=%b",
                 c, rf_wen, rf_waddr, rf_wdata, rr_prio_lsu, e.wen, e.addr, e.data, m_rr);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(0, 0, 0, 0, 1, 5'd7, 32'h77, 0, 0, 0);
    model_push(exp_rdy);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({rf_wen, rf_waddr, rf_wdata, rr_prio_lsu} !== {e.wen, e.addr, e.data, m_rr}) begin
      errors++;
      $display("[TB] FAIL pre_reset_wb: got wen=%b addr=%0d data=%h rr=%b want wen=%b addr=%0d data=%h rr=%b",
               rf_wen, rf_waddr, rf_wdata, rr_prio_lsu, e.wen, e.addr, e.data, m_rr);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({rf_wen, rf_waddr, rf_wdata, rr_prio_lsu} !== 39'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: wen=%b addr=%0d data=%h rr=%b want all 0",
               rf_wen, rf_waddr, rf_wdata, rr_prio_lsu);
    end
    #1;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic dv, av, lv;
    logic [4:0] drd, ard, lrd;
    logic [31:0] dd, ad, ld;
    dv = 0; av = 0; lv = 0;
    drd = 0; ard = 0; lrd = 0;
    dd = 0; ad = 0; ld = 0;
    for (int c = 0; c < 40; c++) begin
      if (!dv) begin dv = ($urandom_range(0, 5) == 0); drd = 5'($urandom); dd = $urandom; end
      if (!av) begin av = ($urandom_range(0, 3) != 0); ard = 5'($urandom); ad = $urandom; end
      if (!lv) begin lv = ($urandom_range(0, 3) != 0); lrd = 5'($urandom); ld = $urandom; end
      drive(($urandom_range(0, 7) == 0), dv, drd, dd, av, ard, ad, lv, lrd, ld);
      model_push(exp_rdy);
      #3;
      checks++;
      if ({dbg_ready, alu_ready, lsu_ready} !== exp_rdy) begin
        errors++;
        $display("[TB] FAIL b2b_ready c%0d: got %b want %b", c, {dbg_ready, alu_ready, lsu_ready}, exp_rdy);
      end
      if (exp_rdy[2]) dv = 0;
      if (exp_rdy[1]) av = 0;
      if (exp_rdy[0]) lv = 0;
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({rf_wen, rf_waddr, rf_wdata, rr_prio_lsu} !== {e.wen, e.addr, e.data, m_rr}) begin
        errors++;
        $display("[TB] FAIL b2b_wb c%0d: got wen=%b addr=%0d data=%h rr=%b want wen=%b addr=%0d data=%h rr=%b",
                 c, rf_wen, rf_waddr, rf_wdata, rr_prio_lsu, e.wen, e.addr, e.data, m_rr);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_contention();
    test_dbg_priority();
    test_x0_hold();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
